// File: rtl/dcache_controller_if.sv
// CPU-side and memory-side signal bundle of the L1 data cache controller.
// The cache is the slave; whoever drives the CPU requests and memory replies is the master.
interface dcache_controller_if;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache with 32-byte lines.
// Hits complete combinationally; misses stall the pipeline while the block is written back and refilled.
module dcache_controller #(
  parameter int INDEX_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_controller_if.slave bus
);
  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_MISS      = 3'd1,
    S_WRITEBACK = 3'd2,
    S_ALLOCATE  = 3'd3,
    S_REFILLED  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [255:0]       data_q [LINES];

  logic               mem_enable_q, mem_enable_d;
  logic               mem_write_q, mem_write_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [255:0]       mem_data_q, mem_data_d;

  logic [INDEX_W-1:0] idx_s;
  logic [TAG_W-1:0]   tag_s;
  logic [2:0]         word_s;
  logic               req_s, hit_s;
  logic [255:0]       line_s;
  logic [31:0]        word_data_s;

  logic               line_we_s;
  logic [255:0]       line_data_s;
  logic               line_dirty_s;
  logic               unused_s;

  assign idx_s       = bus.p1_addr_i[INDEX_W+4:5];
  assign tag_s       = bus.p1_addr_i[31:INDEX_W+5];
  assign word_s      = bus.p1_addr_i[4:2];
  assign unused_s    = ^bus.p1_addr_i[1:0];
  assign req_s       = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign line_s      = data_q[idx_s];
  assign hit_s       = valid_q[idx_s] & (tag_q[idx_s] == tag_s);
  assign word_data_s = line_s[{word_s, 5'b00000} +: 32];

  assign bus.p1_data_o    = ((state_q == S_IDLE) && req_s && hit_s) ? word_data_s : 32'd0;
  assign bus.p1_stall_o   = (state_q == S_IDLE) ? (req_s & ~hit_s) : 1'b1;
  assign bus.mem_enable_o = mem_enable_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;

  // Next-state, line-update and next memory-side output decode.
  always_comb begin
    state_d      = state_q;
    line_we_s    = 1'b0;
    line_data_s  = line_s;
    line_dirty_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_s && hit_s) begin
          if (bus.p1_MemWrite_i) begin
            line_we_s                              = 1'b1;
            line_data_s[{word_s, 5'b00000} +: 32]  = bus.p1_data_i;
            line_dirty_s                           = 1'b1;
          end else begin
            line_we_s = 1'b0;
          end
        end else if (req_s) begin
          state_d = S_MISS;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MISS: begin
        if (valid_q[idx_s] && dirty_q[idx_s]) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_d = S_ALLOCATE;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        if (bus.mem_ack_i) begin
          line_we_s   = 1'b1;
          line_data_s = bus.mem_data_i;
          state_d     = S_REFILLED;
        end else begin
          state_d = S_ALLOCATE;
        end
      end
      S_REFILLED: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    // Memory outputs are registered Moore decodes of the state being entered.
    mem_enable_d = 1'b0;
    mem_write_d  = 1'b0;
    mem_addr_d   = 32'd0;
    mem_data_d   = 256'd0;
    case (state_d)
      S_WRITEBACK: begin
        mem_enable_d = 1'b1;
        mem_write_d  = 1'b1;
        mem_addr_d   = {tag_q[idx_s], idx_s, 5'b00000};
        mem_data_d   = line_s;
      end
      S_ALLOCATE: begin
        mem_enable_d = 1'b1;
        mem_addr_d   = {tag_s, idx_s, 5'b00000};
      end
      default: mem_enable_d = 1'b0;
    endcase
  end

  // Controller state and registered memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'd0;
      mem_data_q   <= 256'd0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
    end
  end

  // Line status bits; reset invalidates everything and discards dirty data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= {LINES{1'b0}};
      dirty_q <= {LINES{1'b0}};
    end else if (line_we_s) begin
      valid_q[idx_s] <= 1'b1;
      dirty_q[idx_s] <= line_dirty_s;
    end else begin
      valid_q <= valid_q;
      dirty_q <= dirty_q;
    end
  end

  // Tag and data arrays carry no reset; valid_q qualifies them.
  always_ff @(posedge clk_i) begin
    if (line_we_s && !rst_i) begin
      tag_q[idx_s]  <= tag_s;
      data_q[idx_s] <= line_data_s;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a table of hit vectors plus hand-written miss,
// write-back and reset sequences served by a scripted memory.
module tb_dcache_controller;
  logic clk = 1'b0;
  logic rst_i;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dcache_controller_if bus();
  dcache_controller #(.INDEX_W(5)) dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic        chk_data;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic rd, input logic wr);
    bus.p1_addr_i     = addr;
    bus.p1_data_i     = wdata;
    bus.p1_MemRead_i  = rd;
    bus.p1_MemWrite_i = wr;
  endtask

  function automatic logic [255:0] mk_block(input logic [31:0] base, input logic [31:0] step);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[k*32 +: 32] = base + step * 32'(k);
    return b;
  endfunction

  // Called just after a rising edge with the request already driven; returns at mid-cycle
  // of the cycle in which the stall drops.
  task automatic serve_miss(input string name, input logic exp_wb, input logic [31:0] wb_addr,
                            input logic [31:0] al_addr, input int wb_delay, input int al_delay,
                            input logic [255:0] refill, input int exp_stall,
                            output logic [255:0] wb_data);
    int stalls = 0;
    int wb_cnt = 0;
    int al_cnt = 0;
    bit done = 1'b0;
    wb_data = 256'd0;
    while (!done) begin
      #4;
      if (bus.p1_stall_o) begin
        stalls++;
        if (bus.mem_enable_o && bus.mem_write_o) begin
          wb_cnt++;
          if (wb_cnt == 1) begin
            chk({name, " wb addr"}, bus.mem_addr_o, wb_addr);
            wb_data = bus.mem_data_o;
          end
          if (wb_cnt == wb_delay) bus.mem_ack_i = 1'b1;
        end else if (bus.mem_enable_o) begin
          al_cnt++;
          if (al_cnt == 1) chk({name, " alloc addr"}, bus.mem_addr_o, al_addr);
          if (al_cnt == al_delay) begin
            bus.mem_ack_i  = 1'b1;
            bus.mem_data_i = refill;
          end
        end
        if (stalls > 40) begin
          chk({name, " timeout"}, 1'b1, 1'b0);
          done = 1'b1;
        end else begin
          tick();
          bus.mem_ack_i = 1'b0;
        end
      end else begin
        done = 1'b1;
      end
    end
    chk({name, " writeback seen"}, (wb_cnt != 0), exp_wb);
    chk({name, " stall cycles"}, stalls, exp_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    logic [255:0] wb;

    vecs[0] = '{32'h0000_0404, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0022};
    vecs[1] = '{32'h0000_0408, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{32'h0000_0408, 32'h0,         1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{32'h0000_041C, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0088};
    vecs[4] = '{32'h0000_040C, 32'h1234_5678, 1'b1, 1'b1, 1'b1, 32'h0000_0044};
    vecs[5] = '{32'h0000_040C, 32'h0,         1'b1, 1'b0, 1'b1, 32'h1234_5678};
    vecs[6] = '{32'h0000_0000, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7] = '{32'h0000_0401, 32'h0,         1'b1, 1'b0, 1'b1, 32'h0000_0011};

    rst_i          = 1'b1;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = 256'd0;
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst_i = 1'b0;
    #4;
    chk("reset stall", bus.p1_stall_o, 1'b0);
    chk("reset mem_enable", bus.mem_enable_o, 1'b0);
    chk("reset mem_write", bus.mem_write_o, 1'b0);
    chk("reset mem_addr", bus.mem_addr_o, 32'h0);
    chk("reset mem_data", bus.mem_data_o, 256'h0);
    chk("reset p1_data", bus.p1_data_o, 32'h0);
    tick();

    // Cold read miss, ack in the third ALLOCATE cycle.
    drive(32'h0000_0400, 32'h0, 1'b1, 1'b0);
    serve_miss("cold", 1'b0, 32'h0, 32'h0000_0400, 0, 3, mk_block(32'h11, 32'h11), 6, wb);
    chk("cold data", bus.p1_data_o, 32'h11);
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].wr);
      #4;
      if (vecs[i].chk_data) chk($sformatf("vec%0d data", i), bus.p1_data_o, vecs[i].exp_data);
      chk($sformatf("vec%0d stall", i), bus.p1_stall_o, 1'b0);
      chk($sformatf("vec%0d mem_enable", i), bus.mem_enable_o, 1'b0);
      tick();
    end

    // Dirty conflict on index 0 forces a write-back of the 0x400 line.
    drive(32'h0000_0800, 32'h0, 1'b1, 1'b0);
    serve_miss("dirty", 1'b1, 32'h0000_0400, 32'h0000_0800, 2, 1, mk_block(32'hA000_0000, 32'h1), 6, wb);
    chk("dirty wb word2", wb[95:64], 32'hDEAD_BEEF);
    chk("dirty wb word3", wb[127:96], 32'h1234_5678);
    chk("dirty wb word0", wb[31:0], 32'h11);
    chk("dirty data", bus.p1_data_o, 32'hA000_0000);
    tick();

    // Clean conflict goes straight to ALLOCATE.
    drive(32'h0000_0C04, 32'h0, 1'b1, 1'b0);
    serve_miss("clean", 1'b0, 32'h0, 32'h0000_0C00, 0, 1, mk_block(32'h3000_0000, 32'h10), 4, wb);
    chk("clean data", bus.p1_data_o, 32'h3000_0010);
    tick();

    // Store miss allocates, then merges its word and marks the line dirty.
    drive(32'h0000_0424, 32'hCAFE_F00D, 1'b0, 1'b1);
    serve_miss("store miss", 1'b0, 32'h0, 32'h0000_0420, 0, 2, mk_block(32'h5000, 32'h1), 5, wb);
    tick();
    drive(32'h0000_0424, 32'h0, 1'b1, 1'b0);
    #4;
    chk("store merged", bus.p1_data_o, 32'hCAFE_F00D);
    tick();
    drive(32'h0000_0420, 32'h0, 1'b1, 1'b0);
    #4;
    chk("store refill word0", bus.p1_data_o, 32'h5000);
    tick();
    drive(32'h0000_0820, 32'h0, 1'b1, 1'b0);
    serve_miss("store victim", 1'b1, 32'h0000_0420, 32'h0000_0820, 1, 1, mk_block(32'h7000, 32'h1), 5, wb);
    chk("store victim word1", wb[63:32], 32'hCAFE_F00D);
    chk("store victim data", bus.p1_data_o, 32'h7000);
    tick();

    // Reset in the middle of ALLOCATE, with an ack in the same cycle.
    drive(32'h0000_1000, 32'h0, 1'b1, 1'b0);
    #4;
    chk("rst seq miss stall", bus.p1_stall_o, 1'b1);
    tick();
    tick();
    #4;
    chk("rst seq alloc enable", bus.mem_enable_o, 1'b1);
    chk("rst seq alloc addr", bus.mem_addr_o, 32'h0000_1000);
    rst_i          = 1'b1;
    bus.mem_ack_i  = 1'b1;
    bus.mem_data_i = mk_block(32'hEEEE_0000, 32'h1);
    drive(32'h0000_1000, 32'h0, 1'b0, 1'b0);
    tick();
    rst_i         = 1'b0;
    bus.mem_ack_i = 1'b0;
    #4;
    chk("after rst mem_enable", bus.mem_enable_o, 1'b0);
    chk("after rst stall", bus.p1_stall_o, 1'b0);
    chk("after rst mem_addr", bus.mem_addr_o, 32'h0);
    tick();
    drive(32'h0000_0C00, 32'h0, 1'b1, 1'b0);
    serve_miss("post reset", 1'b0, 32'h0, 32'h0000_0C00, 0, 1, mk_block(32'h9000, 32'h1), 4, wb);
    chk("post reset data", bus.p1_data_o, 32'h9000);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
